obstacle_spawn_scheduler: RTL

Sequences the obstacle datapath while the game is in PLAYING (state 2'b01). It generates the frame tick, allocates obstacle slots at a difficulty-scaled interval with a pseudo-random lane, and gates raw collisions with an invulnerability window. The gated one-cycle `collision` pulse feeds the game state machine's `collision` input. All slot, level and invulnerability state clears whenever the game leaves PLAYING.

---
 rtl/obstacle_spawn_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle spawn scheduler: frame tick, slot allocation at a difficulty-scaled
// interval with an LFSR lane pick, and invulnerability gating of collisions.
module obstacle_spawn_scheduler #(
    parameter int          TICK_DIV     = 833333,
    parameter int          NUM_SLOTS    = 4,
    parameter int          INIT_GAP     = 90,
    parameter int          MIN_GAP      = 30,
    parameter int          GAP_STEP     = 5,
    parameter int          LEVEL_FRAMES = 600,
    parameter int          IFRAMES      = 60,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           state,
    input  logic                 raw_collision,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic                 frame_tick,
    output logic                 spawn,
    output logic [2:0]           spawn_slot,
    output logic [1:0]           spawn_lane,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic                 collision,
    output logic                 invuln,
    output logic [3:0]           level
);

    localparam int LVL_W = $clog2(LEVEL_FRAMES + 1);

    if (INIT_GAP > 255) begin : g_bad_init_gap
        $error("INIT_GAP must fit in 8 bits");
    end
    if (IFRAMES > 255) begin : g_bad_iframes
        $error("IFRAMES must fit in 8 bits");
    end
    if (NUM_SLOTS < 2 || NUM_SLOTS > 8) begin : g_bad_slots
        $error("NUM_SLOTS must be 2..8");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } fsm_t;

    fsm_t                 fsm, fsm_next;
    logic [19:0]          div_cnt;
    logic                 tick_q;
    logic [15:0]          lfsr;
    logic                 raw_q;
    logic [7:0]           gap, gap_next, gap_cnt, iframe_cnt;
    logic [LVL_W-1:0]     lvl_cnt;
    logic [3:0]           level_q;
    logic [NUM_SLOTS-1:0] slots, spawn_mask;
    logic                 playing, active, rise, have_free;
    logic [2:0]           free_idx;

    assign playing     = (state == 2'b01);
    assign active      = playing && (fsm != IDLE);
    assign rise        = raw_collision && !raw_q;
    assign frame_tick  = tick_q;
    assign slot_active = slots;
    assign level       = level_q;
    assign invuln      = (fsm == HIT);

    // Free-running frame divider; tick is registered on the wrap cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (div_cnt == 20'(TICK_DIV - 1)) begin
            div_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 20'd1;
            tick_q  <= 1'b0;
        end
    end

    // 16-bit Fibonacci LFSR (taps 16,14,13,11) and collision edge register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr  <= LFSR_SEED;
            raw_q <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            raw_q <= raw_collision;
        end
    end

    // Lowest free slot in the registered occupancy mask.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!slots[i] && !have_free) begin
                have_free = 1'b1;
                free_idx  = 3'(i);
            end
        end
    end

    // Next spawn gap after a level-up, floored at MIN_GAP without underflow.
    always_comb begin
        if (int'(gap) >= MIN_GAP + GAP_STEP) gap_next = gap - 8'(GAP_STEP);
        else                                 gap_next = 8'(MIN_GAP);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) fsm <= IDLE;
        else      fsm <= fsm_next;
    end

    // Next-state logic plus the combinational spawn and collision strobes.
    always_comb begin
        fsm_next   = fsm;
        collision  = 1'b0;
        spawn      = 1'b0;
        spawn_slot = '0;
        spawn_lane = '0;
        spawn_mask = '0;
        case (fsm)
            IDLE: if (playing) fsm_next = RUN;
            RUN: begin
                if (rise) begin
                    fsm_next  = HIT;
                    collision = 1'b1;
                end
            end
            HIT: if (tick_q && iframe_cnt <= 8'd1) fsm_next = RUN;
            default: fsm_next = IDLE;
        endcase
        if (!playing) begin
            fsm_next  = IDLE;
            collision = 1'b0;
        end
        if (active && gap_cnt == 8'd0 && have_free) begin
            spawn      = 1'b1;
            spawn_slot = free_idx;
            spawn_lane = lfsr[1:0];
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            spawn_mask[i] = spawn && (free_idx == 3'(i));
        end
    end

    // Game datapath: slots, spawn gap, difficulty and iframes; held cleared
    // whenever the scheduler is not engaged in PLAYING.
    always_ff @(posedge clk) begin
        if (!rst || !active) begin
            slots      <= '0;
            gap        <= 8'(INIT_GAP);
            gap_cnt    <= 8'(INIT_GAP);
            lvl_cnt    <= '0;
            level_q    <= '0;
            iframe_cnt <= '0;
        end else begin
            slots <= (slots & ~slot_done) | spawn_mask;
            if (spawn)                            gap_cnt <= gap;
            else if (tick_q && gap_cnt != 8'd0)   gap_cnt <= gap_cnt - 8'd1;
            if (tick_q) begin
                if (lvl_cnt == LVL_W'(LEVEL_FRAMES - 1)) begin
                    lvl_cnt <= '0;
                    gap     <= gap_next;
                    if (level_q != 4'd15) level_q <= level_q + 4'd1;
                end else begin
                    lvl_cnt <= lvl_cnt + 1'b1;
                end
            end
            if (collision)
                iframe_cnt <= 8'(IFRAMES);
            else if (fsm == HIT && tick_q && iframe_cnt != 8'd0)
                iframe_cnt <= iframe_cnt - 8'd1;
        end
    end

endmodule
